// File: rtl/column_prefetch_buffer.sv
// Column prefetch buffer: fetches one texture column from ROM into the back bank of a
// ping-pong store and swaps it to the front only at a strip refresh boundary.
module column_prefetch_buffer #(
  parameter int unsigned LED_COUNT  = 52,
  parameter int unsigned TEX_WIDTH  = 64,
  parameter int unsigned NUM_FRAMES = 30,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned PX_BITS    = 6,
  parameter int unsigned COL_BITS   = 6,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned ADDR_BITS  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COL_BITS-1:0]   col_in,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic [PX_BITS-1:0]    rd_px_num,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [COL_BITS-1:0]   col_shown,
  output logic                  swap_pulse,
  output logic                  fetch_busy
);

  localparam logic [PX_BITS-1:0]   LastPx      = PX_BITS'(LED_COUNT - 1);
  localparam logic [PX_BITS-1:0]   DoneK       = PX_BITS'(LED_COUNT);
  localparam logic [ADDR_BITS-1:0] FrameStride = ADDR_BITS'(TEX_WIDTH * LED_COUNT);
  localparam logic [ADDR_BITS-1:0] RowStride   = ADDR_BITS'(TEX_WIDTH);

  typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

  state_e                  state_q, state_d;
  logic [COL_BITS-1:0]     col_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic                    fetch_req_q, fetch_req_d;
  logic [COL_BITS-1:0]     tgt_col_q, tgt_col_d;
  logic [FRAME_BITS-1:0]   tgt_frame_q, tgt_frame_d;
  logic [PX_BITS-1:0]      k_q, k_d;
  logic                    front_sel_q, front_sel_d;
  logic                    front_valid_q, front_valid_d;
  logic                    back_valid_q, back_valid_d;
  logic [COL_BITS-1:0]     back_col_q, back_col_d;
  logic [COL_BITS-1:0]     col_shown_q, col_shown_d;
  logic                    swap_pulse_q, swap_pulse_d;
  logic                    fetch_busy_q, fetch_busy_d;
  logic [ADDR_BITS-1:0]    rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0]   pixel_out_q, pixel_out_d;
  logic [PX_BITS-1:0]      prev_px_q;
  logic [DATA_WIDTH-1:0]   mem_q [2][LED_COUNT];

  logic                    tgt_change, boundary, swap;
  logic                    wr_en;
  logic [PX_BITS-1:0]      wr_idx;
  logic                    rd_bank, rd_ok;
  logic [PX_BITS-1:0]      rd_idx;

  function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [FRAME_BITS-1:0] f,
                                                    input logic [COL_BITS-1:0]   c,
                                                    input logic [PX_BITS-1:0]    k);
    return ADDR_BITS'(f) * FrameStride + ADDR_BITS'(k) * RowStride + ADDR_BITS'(c);
  endfunction

  // Fetch sequencing, abort/restart, swap decision and request tracking.
  always_comb begin
    state_d       = state_q;
    fetch_req_d   = fetch_req_q;
    tgt_col_d     = tgt_col_q;
    tgt_frame_d   = tgt_frame_q;
    k_d           = k_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    back_valid_d  = back_valid_q;
    back_col_d    = back_col_q;
    col_shown_d   = col_shown_q;
    swap_pulse_d  = 1'b0;
    fetch_busy_d  = fetch_busy_q;
    rom_addr_d    = rom_addr_q;
    wr_en         = 1'b0;
    wr_idx        = k_q - PX_BITS'(1);

    tgt_change = {col_in, frame_in} != {col_q, frame_q};
    boundary   = (rd_px_num == '0) && (prev_px_q != '0);
    swap       = boundary && back_valid_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_req_q) begin
          state_d      = StFetch;
          tgt_col_d    = col_q;
          tgt_frame_d  = frame_q;
          k_d          = '0;
          rom_addr_d   = pix_addr(frame_q, col_q, '0);
          fetch_req_d  = 1'b0;
          fetch_busy_d = 1'b1;
        end
      end
      StFetch: begin
        if (fetch_req_q) begin
          // Target moved mid-fetch: drop the partial column and start over.
          tgt_col_d   = col_q;
          tgt_frame_d = frame_q;
          k_d         = '0;
          rom_addr_d  = pix_addr(frame_q, col_q, '0);
          fetch_req_d = 1'b0;
        end else begin
          // rom_data lags rom_addr by one cycle, so entry k lands at cycle k+1.
          wr_en = (k_q != '0);
          if (k_q == DoneK) begin
            state_d      = StWait;
            back_valid_d = 1'b1;
            back_col_d   = tgt_col_q;
            fetch_busy_d = 1'b0;
          end else begin
            k_d = k_q + PX_BITS'(1);
            if (k_q < LastPx) rom_addr_d = pix_addr(tgt_frame_q, tgt_col_q, k_q + PX_BITS'(1));
          end
        end
      end
      StWait: begin
        if (swap) begin
          front_sel_d   = ~front_sel_q;
          front_valid_d = 1'b1;
          col_shown_d   = back_col_q;
          back_valid_d  = 1'b0;
          swap_pulse_d  = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tgt_change) fetch_req_d = 1'b1;
  end

  // Read path reads the post-swap bank on a swap cycle so pixel 0 belongs to the new column.
  always_comb begin
    rd_bank     = swap ? ~front_sel_q : front_sel_q;
    rd_ok       = (swap || front_valid_q) && (rd_px_num <= LastPx);
    rd_idx      = rd_ok ? rd_px_num : '0;
    pixel_out_d = rd_ok ? mem_q[rd_bank][rd_idx] : '0;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fetch_req_q   <= 1'b1;
      tgt_col_q     <= '0;
      tgt_frame_q   <= '0;
      k_q           <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      back_valid_q  <= 1'b0;
      back_col_q    <= '0;
      col_shown_q   <= '0;
      swap_pulse_q  <= 1'b0;
      fetch_busy_q  <= 1'b0;
      rom_addr_q    <= '0;
      pixel_out_q   <= '0;
      prev_px_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_req_q   <= fetch_req_d;
      tgt_col_q     <= tgt_col_d;
      tgt_frame_q   <= tgt_frame_d;
      k_q           <= k_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      back_valid_q  <= back_valid_d;
      back_col_q    <= back_col_d;
      col_shown_q   <= col_shown_d;
      swap_pulse_q  <= swap_pulse_d;
      fetch_busy_q  <= fetch_busy_d;
      rom_addr_q    <= rom_addr_d;
      pixel_out_q   <= pixel_out_d;
      prev_px_q     <= rd_px_num;
    end
  end

  // Target sampler keeps loading through reset so the first fetch uses the live target.
  always_ff @(posedge clk) begin
    col_q   <= col_in;
    frame_q <= frame_in;
  end

  // Back-bank write port; never the bank being read.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[~front_sel_q][wr_idx] <= rom_data;
  end

  assign pixel_out  = pixel_out_q;
  assign rom_addr   = rom_addr_q;
  assign col_shown  = col_shown_q;
  assign swap_pulse = swap_pulse_q;
  assign fetch_busy = fetch_busy_q;

endmodule
